// File: rtl/pulse_pacer_pkg.sv
// Shared definitions for the pulse pacer placed ahead of the fast-to-slow pulse synchroniser.
// Optional build macro used by the top: PULSE_PACER_DROP_CNT_EN.
package pulse_pacer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFire = 2'd1,
        StGap  = 2'd2
    } pacer_state_t;

    // Smallest legal pulse spacing; the gap counter is loaded with GAP minus this.
    localparam int unsigned PACER_GAP_MIN = 2;

    // The synchroniser needs this many slow-clock periods between pulses.
    localparam int unsigned PACER_SPACING_MULT = 5;

    // Recommended GAP in clka cycles from the two clock frequencies (any common unit),
    // rounding the ratio up and adding a caller-chosen margin.
    function automatic int unsigned pacer_recommended_gap(input int unsigned fast_freq,
                                                          input int unsigned slow_freq,
                                                          input int unsigned margin);
        int unsigned ratio;
        int unsigned gap;
        ratio = (slow_freq == 0) ? 1 : (fast_freq + slow_freq - 1) / slow_freq;
        gap   = PACER_SPACING_MULT * ratio + margin;
        return (gap < PACER_GAP_MIN) ? PACER_GAP_MIN : gap;
    endfunction

endpackage

// File: rtl/pulse_pacer_cnt.sv
// Saturating up/down backlog counter. A simultaneous inc and dec leaves the count alone;
// an inc that finds the counter full is dropped and reported on ovf for one cycle.
module pulse_pacer_cnt
    import pulse_pacer_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count update with saturation at both ends; ovf is a registered one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (inc && !dec) begin
                if (count == CNT_MAX) begin
                    ovf <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else if (dec && !inc && count != '0) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pulse_pacer.sv
// Paces a dense stream of event pulses into single-cycle pulses exactly GAP clka cycles
// apart, so the downstream pulse synchroniser never sees pulses closer than it can handle.
// Optional build macro: PULSE_PACER_DROP_CNT_EN adds a saturating drop_cnt output.
module pulse_pacer
    import pulse_pacer_pkg::*;
#(
    parameter int unsigned GAP   = 12,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    output logic             dout,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             ovf
`ifdef PULSE_PACER_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    // Gap counter only has to hold GAP-2.
    localparam int unsigned GW = (GAP > 2) ? $clog2(GAP - 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - PACER_GAP_MIN);

    pacer_state_t  state;
    logic [GW-1:0] gap_cnt;
    logic          want;
    logic          fire;
    logic          inc;

    // A fire is taken from IDLE or at the end of a GAP; a din arriving on that edge
    // bypasses the backlog so an idle event is not delayed by a cycle.
    always_comb begin
        want = en && (pending != '0 || din);
        fire = want && (state == StIdle || (state == StGap && gap_cnt == '0));
        inc  = din && !rst;
    end

    pulse_pacer_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clka),
        .rst   (rst),
        .inc   (inc),
        .dec   (fire),
        .count (pending),
        .ovf   (ovf)
    );

    // Pacing FSM; dout is registered and high exactly while in FIRE.
    always_ff @(posedge clka) begin
        if (rst) begin
            state   <= StIdle;
            gap_cnt <= '0;
            dout    <= 1'b0;
        end else begin
            dout <= fire;
            case (state)
                StIdle: begin
                    if (fire) state <= StFire;
                end
                StFire: begin
                    state   <= StGap;
                    gap_cnt <= GAP_LOAD;
                end
                StGap: begin
                    if (gap_cnt == '0) begin
                        state <= fire ? StFire : StIdle;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Busy while anything is queued or a pulse/gap is still in progress.
    always_comb begin
        busy = (pending != '0) || (state != StIdle);
    end

`ifdef PULSE_PACER_DROP_CNT_EN
    // Running count of dropped events, one per ovf pulse, sticking at all-ones.
    always_ff @(posedge clka) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (ovf && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule
